sram_controller: RTL
====================

// Module: sram_controller
// PURPOSE
//  Multi-cycle bridge between the MEM stage and the board's 16-bit asynchronous SRAM.
//  Turns one 32-bit load/store from the MEM stage into two 16-bit SRAM accesses.
//  Drives ready=0 while busy; top level ORs ~ready into freeze for all pipeline regs.
//  Loads return a 32-bit word to MEM_Reg.
// PARAMETERS
//  WAIT_CYCLES  2     cycles each 16-bit half-access is held on the SRAM bus (>=1)
//  BASE_ADDR    1024  CPU byte address that maps to SRAM word 0
//  SRAM_AW      18    SRAM halfword address width
// PORTS
//  clk          in   1        single clock; all state changes on posedge
//  rst          in   1        synchronous, active-high reset
//  wr_en        in   1        MEM-stage store request (level, held while ready=0)
//  rd_en        in   1        MEM-stage load request (level, held while ready=0)
//  address      in   32       CPU byte address (ALU result)
//  wr_data      in   32       store data (Val_Rm)
//  rd_data      out  32       load result; registered, held until next load completes
//  ready        out  1        1 = request done or no request; 0 = freeze pipeline
//  SRAM_DQ      inout 16      SRAM data bus; high-Z unless writing
//  SRAM_ADDR    out  SRAM_AW  SRAM halfword address
//  SRAM_WE_N    out  1        active-low write enable
// BEHAVIOUR
//  Reset values: state=IDLE, rd_data=0, SRAM_WE_N=1, SRAM_ADDR=0, DQ=Z.
//  Reset mid-access aborts on the next edge. A store may leave its low half written.
//  Mapping: w = (address-BASE_ADDR)>>2, computed in 32 bits. Low half at {w,1'b0}; high half at {w,1'b1}.
//  The mapped address is truncated to SRAM_AW bits, so addresses below BASE wrap modulo 2^SRAM_AW.
//  address[1:0] is ignored.
//  FSM: IDLE -> LO -> HI -> DONE -> IDLE.
//   IDLE: when rd_en|wr_en, capture address/data/op and go to LO.
//   LO/HI: hold the half-access for WAIT_CYCLES cycles (down-counter).
//    On writes, WE_N=0 and DQ is driven for all of these cycles except the last, where WE_N=1 and DQ is still driven.
//    On reads, the low half is latched at the end of LO and the high half at the end of HI.
//   DONE: ready=1 for exactly one cycle; rd_data updated on entry (reads only). Next state IDLE.
//  ready = (IDLE & ~rd_en & ~wr_en) | DONE, combinational.
//  Latency: request first seen in cycle 0 -> ready=1 in cycle 2*WAIT_CYCLES+1.
//  Simultaneous rd_en & wr_en: the write wins; no read is performed.
//  Requests arriving outside IDLE are ignored until the FSM returns to IDLE.
//  The pipeline advances on the DONE edge, so the IDLE cycle after DONE sees the next instruction.
// CONFIGURATION
//  SRAM_WRITE_BUFFER_EN defined: one-entry posted-write buffer.
//   A store seen in IDLE is captured and ready stays 1 in that cycle; the write drains in the background (LO/HI, no DONE).
//   Any request during the drain sees ready=0 until the drain ends and its own access completes, so RAW order is kept.
//   Reads are unchanged.
//  Undefined: stores stall exactly like loads (2*WAIT_CYCLES+1 cycles).
// STRUCTURE
//  Package arm_mem_pkg: typedef enum logic[1:0] {IDLE,LO,HI,DONE} sram_state_t; localparams for default BASE_ADDR and SRAM_AW.
//  Sub-module sram_bus_if: tristate DQ driver plus ADDR/WE_N output registers. The FSM stays in sram_controller.
// TESTING
//  Bench uses a behavioural async SRAM model; WAIT_CYCLES=2, BASE_ADDR=1024.
//  1) rst=1 for 2 cycles with rd_en=1 -> ready=1, WE_N=1, DQ=Z, rd_data=0 throughout.
//  2) wr_en, address=1024, wr_data=32'hDEADBEEF -> ready=0 for cycles 0-4, 1 in cycle 5.
//     SRAM[0]=16'hBEEF, SRAM[1]=16'hDEAD.
//  3) rd_en, address=1024 after test 2 -> ready in cycle 5; rd_data=32'hDEADBEEF, held during a later store.
//  4) rd_en & wr_en together, address=1028, wr_data=1 -> SRAM[2]=1, SRAM[3]=0; rd_data unchanged.
//  5) rst pulsed during HI of a read -> IDLE next cycle, ready=1, rd_data unchanged, DQ=Z.
//  6) SRAM_WRITE_BUFFER_EN: store then load to the same address back-to-back.
//     Store sees ready=1 in cycle 0; load stalls until the drain finishes, then returns the new value.

Source files
------------

// File: rtl/arm_mem_pkg.sv
// Shared types and defaults for the MEM-stage SRAM bridge.
package arm_mem_pkg;
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} sram_state_t;

  localparam logic [31:0] DEF_BASE_ADDR = 32'd1024;
  localparam int          DEF_SRAM_AW   = 18;
endpackage

// File: rtl/sram_bus_if.sv
// SRAM pin driver: registered address / write-enable / data-out and the DQ tristate.
module sram_bus_if
  import arm_mem_pkg::*;
#(
  parameter int SRAM_AW = DEF_SRAM_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SRAM_AW-1:0] addr_d,
  input  logic               we_n_d,
  input  logic               oe_d,
  input  logic [15:0]        dout_d,
  output logic [15:0]        din,
  inout  wire  [15:0]        SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N
);
  logic        oe_q;
  logic [15:0] dout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      SRAM_ADDR <= '0;
      SRAM_WE_N <= 1'b1;
      oe_q      <= 1'b0;
    end else begin
      SRAM_ADDR <= addr_d;
      SRAM_WE_N <= we_n_d;
      oe_q      <= oe_d;
    end
  end

  always_ff @(posedge clk) begin
    dout_q <= dout_d;
  end

  assign SRAM_DQ = oe_q ? dout_q : 16'bz;
  assign din     = SRAM_DQ;
endmodule

// File: rtl/sram_controller.sv
// Splits one 32-bit MEM-stage load/store into two 16-bit async SRAM accesses.
// Define SRAM_WRITE_BUFFER_EN for a one-entry posted-write buffer.
module sram_controller
  import arm_mem_pkg::*;
#(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int          SRAM_AW     = DEF_SRAM_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        wr_data,
  output logic [31:0]        rd_data,
  output logic               ready,
  inout  wire  [15:0]        SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N
);
`ifdef SRAM_WRITE_BUFFER_EN
  localparam bit POSTED_WR = 1'b1;
`else
  localparam bit POSTED_WR = 1'b0;
`endif
  localparam int            CW       = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYCLES);
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] TWO      = CW'(2);

  sram_state_t        state;
  logic [CW-1:0]      cnt;
  logic               is_wr;
  logic               posted;
  logic [SRAM_AW-2:0] word_q;
  logic [31:0]        wdata_q;
  logic [15:0]        lo_q;
  logic [15:0]        din;
  logic               req;
  logic [SRAM_AW-2:0] word_in;
  logic [SRAM_AW-1:0] addr_d;
  logic               we_n_d;
  logic               oe_d;
  logic [15:0]        dout_d;

  assign req     = rd_en | wr_en;
  // Offset computed in 32 bits, then truncated: addresses below BASE_ADDR wrap.
  assign word_in = (SRAM_AW-1)'((address - BASE_ADDR) >> 2);

  always_comb begin
    ready = rst | (state == DONE) | ((state == IDLE) & ~req);
    if (POSTED_WR)
      ready = ready | ((state == IDLE) & wr_en) |
              (((state == LO) | (state == HI)) & posted & ~req);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      is_wr   <= 1'b0;
      posted  <= 1'b0;
      rd_data <= '0;
    end else begin
      case (state)
        IDLE: if (req) begin
          state  <= LO;
          cnt    <= CNT_INIT;
          is_wr  <= wr_en;
          posted <= POSTED_WR & wr_en;
        end
        LO: if (cnt == ONE) begin
          state <= HI;
          cnt   <= CNT_INIT;
        end else begin
          cnt <= cnt - ONE;
        end
        HI: if (cnt == ONE) begin
          state <= posted ? IDLE : DONE;
          if (!is_wr) rd_data <= {din, lo_q};
        end else begin
          cnt <= cnt - ONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      word_q  <= word_in;
      wdata_q <= wr_data;
    end
    if (state == LO && cnt == ONE) lo_q <= din;
  end

  // Bus values for the coming cycle; WE_N rises one cycle before each half ends.
  always_comb begin
    addr_d = SRAM_ADDR;
    we_n_d = 1'b1;
    oe_d   = 1'b0;
    dout_d = wdata_q[15:0];
    unique case (state)
      IDLE: if (req) begin
        addr_d = {word_in, 1'b0};
        oe_d   = wr_en;
        we_n_d = !(wr_en && WAIT_CYCLES > 1);
        dout_d = wr_data[15:0];
      end
      LO: begin
        oe_d = is_wr;
        if (cnt == ONE) begin
          addr_d = {word_q, 1'b1};
          dout_d = wdata_q[31:16];
          we_n_d = !(is_wr && WAIT_CYCLES > 1);
        end else begin
          we_n_d = !(is_wr && cnt != TWO);
        end
      end
      HI: if (cnt != ONE) begin
        oe_d   = is_wr;
        dout_d = wdata_q[31:16];
        we_n_d = !(is_wr && cnt != TWO);
      end
      default: ;
    endcase
  end

  sram_bus_if #(.SRAM_AW(SRAM_AW)) u_bus (
    .clk       (clk),
    .rst       (rst),
    .addr_d    (addr_d),
    .we_n_d    (we_n_d),
    .oe_d      (oe_d),
    .dout_d    (dout_d),
    .din       (din),
    .SRAM_DQ   (SRAM_DQ),
    .SRAM_ADDR (SRAM_ADDR),
    .SRAM_WE_N (SRAM_WE_N)
  );
endmodule
